// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and elaboration-time helpers for the DDS/NCO.
// Holds the waveform mode codes, the dither LFSR definition and the constant
// function that builds the quarter-wave sine table with integer arithmetic.
package dds_pkg;

   localparam logic [1:0] MODE_SINE   = 2'd0;
   localparam logic [1:0] MODE_SAW    = 2'd1;
   localparam logic [1:0] MODE_SQUARE = 2'd2;
   localparam logic [1:0] MODE_TRI    = 2'd3;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1: taps on bits 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // pi/2 scaled by 2**30
   localparam longint HALF_PI_Q30 = 64'sd1686629713;

   // Feedback bit of the dither LFSR
   function automatic logic lfsr_fb(input logic [15:0] state);
      return ^(state & LFSR_TAPS);
   endfunction

   // round(amp * sin(pi/2 * j / q)), evaluated at elaboration with a Q30
   // Taylor series so no real arithmetic reaches the netlist.
   function automatic int sine_entry(input int j, input int q, input int amp);
      longint x;
      longint x2;
      longint term;
      longint sum;
      longint div;
      x    = (HALF_PI_Q30 * longint'(j)) / longint'(q);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 7; n++) begin
         div  = longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
         term = -(((term * x2) >>> 30) / div);
         sum  = sum + term;
      end
      return int'((longint'(amp) * sum + 64'sd536870912) >>> 30);
   endfunction

endpackage

// File: rtl/dds_nco_if.sv
// dds_nco_if: sample stream from the NCO to a DAC or stream sink.
// The master drives valid/data/wrap, the slave drives ready.
interface dds_nco_if #(
   parameter int DATA_W = 8
) ();
   logic              out_vld;
   logic              out_rdy;
   logic [DATA_W-1:0] out_data;
   logic              out_wrap;

   modport master (output out_vld, output out_data, output out_wrap, input out_rdy);
   modport slave  (input out_vld, input out_data, input out_wrap, output out_rdy);
endinterface

// File: rtl/dds_qlut.sv
// dds_qlut: combinational quarter-wave sine table (Q+1 entries) plus
// quadrant mirroring. Input is the top LUT_AW phase bits; output is an
// offset-binary sample centred on 2**(DATA_W-1).
module dds_qlut
   import dds_pkg::*;
#(
   parameter int LUT_AW = 8,
   parameter int DATA_W = 8
) (
   input  logic [LUT_AW-1:0] phase,
   output logic [DATA_W-1:0] sample
);

   localparam int Q   = 2 ** (LUT_AW - 2);
   localparam int AMP = 2 ** (DATA_W - 1) - 1;
   localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [LUT_AW-2:0] Q_IDX = {1'b1, {(LUT_AW-2){1'b0}}};

   logic [DATA_W-2:0] lut_s [0:Q];

   for (genvar j = 0; j <= Q; j++) begin : g_lut
      localparam int VAL = sine_entry(j, Q, AMP);
      assign lut_s[j] = VAL[DATA_W-2:0];
   end

   logic [1:0]        quad_s;
   logic [LUT_AW-3:0] idx_s;
   logic [LUT_AW-2:0] sel_s;
   logic [DATA_W-2:0] mag_s;

   // Mirror the index in odd quadrants, negate around midpoint in the lower half
   always_comb begin
      quad_s = phase[LUT_AW-1 -: 2];
      idx_s  = phase[LUT_AW-3:0];
      if (quad_s[0]) begin
         sel_s = Q_IDX - {1'b0, idx_s};
      end else begin
         sel_s = {1'b0, idx_s};
      end
      mag_s = lut_s[sel_s];
      if (quad_s[1]) begin
         sample = MID - {1'b0, mag_s};
      end else begin
         sample = MID + {1'b0, mag_s};
      end
   end

endmodule

// File: rtl/dds_nco.sv
// dds_nco: parametrised DDS/NCO with phase accumulator, phase offset and four
// waveforms (sine, saw, square, triangle). Two-stage pipeline behind a
// valid/ready stream; the accumulator only advances when a sample can move.
// Optional dither: define DDS_DITHER_EN to add a 16-bit LFSR into the phase
// bits below the lookup point; undefined gives bit-exact waveforms.
module dds_nco
   import dds_pkg::*;
#(
   parameter int PHASE_W = 16,
   parameter int LUT_AW  = 8,
   parameter int DATA_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               acc_clr,
   input  logic               cfg_load,
   input  logic [PHASE_W-1:0] cfg_freq,
   input  logic [PHASE_W-1:0] cfg_phase,
   input  logic [1:0]         cfg_mode,
   dds_nco_if.master          stream
);

   // active configuration
   logic [PHASE_W-1:0] freq_r;
   logic [PHASE_W-1:0] phase_r;
   logic [1:0]         mode_r;

   // accumulator and stage 1
   logic [PHASE_W-1:0] acc_r;
   logic               wrap_flag_r;
   logic [PHASE_W-1:0] p1_r;
   logic               v1_r;
   logic               w1_r;
   logic [1:0]         m1_r;

   // output stage
   logic               out_vld_r;
   logic [DATA_W-1:0]  out_data_r;
   logic               out_wrap_r;

   logic               stall_s;
   logic               advance_s;
   logic [PHASE_W:0]   sum_s;
   logic [PHASE_W-1:0] dither_s;
   logic [PHASE_W-1:0] p1_next_s;
   logic [PHASE_W+DATA_W-1:0] ext_s;
   logic [DATA_W-1:0]  saw_s;
   logic [DATA_W-1:0]  tri_base_s;
   logic [DATA_W-1:0]  sine_s;
   logic [DATA_W-1:0]  wave_s;

   assign stall_s   = out_vld_r & ~stream.out_rdy;
   assign advance_s = en & ~stall_s & ~acc_clr;
   assign sum_s     = {1'b0, acc_r} + {1'b0, freq_r};
   assign p1_next_s = acc_r + phase_r + dither_s;

`ifdef DDS_DITHER_EN
   localparam logic [PHASE_W-1:0] DITHER_MASK = {PHASE_W{1'b1}} >> LUT_AW;

   logic [15:0] lfsr_r;

   // Dither LFSR steps once per accumulator advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_r <= LFSR_SEED;
      end else if (advance_s) begin
         lfsr_r <= {lfsr_r[14:0], lfsr_fb(lfsr_r)};
      end
   end

   assign dither_s = PHASE_W'(lfsr_r) & DITHER_MASK;
`else
   assign dither_s = {PHASE_W{1'b0}};
`endif

   // Capture new configuration whenever requested, even while stalled or clearing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         freq_r  <= {PHASE_W{1'b0}};
         phase_r <= {PHASE_W{1'b0}};
         mode_r  <= MODE_SINE;
      end else if (cfg_load) begin
         freq_r  <= cfg_freq;
         phase_r <= cfg_phase;
         mode_r  <= cfg_mode;
      end
   end

   // Accumulator and stage 1: offset phase, wrap flag and mode travel together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r       <= {PHASE_W{1'b0}};
         wrap_flag_r <= 1'b1;
         p1_r        <= {PHASE_W{1'b0}};
         v1_r        <= 1'b0;
         w1_r        <= 1'b0;
         m1_r        <= MODE_SINE;
      end else if (acc_clr) begin
         acc_r       <= {PHASE_W{1'b0}};
         wrap_flag_r <= 1'b1;
         v1_r        <= 1'b0;
      end else if (advance_s) begin
         acc_r       <= sum_s[PHASE_W-1:0];
         wrap_flag_r <= sum_s[PHASE_W];
         p1_r        <= p1_next_s;
         v1_r        <= 1'b1;
         w1_r        <= wrap_flag_r;
         m1_r        <= mode_r;
      end else if (!stall_s) begin
         v1_r        <= 1'b0;
      end
   end

   dds_qlut #(
      .LUT_AW (LUT_AW),
      .DATA_W (DATA_W)
   ) u_qlut (
      .phase  (p1_r[PHASE_W-1 -: LUT_AW]),
      .sample (sine_s)
   );

   // Waveform select on the stage-1 phase; saw and triangle zero-pad if narrow
   always_comb begin
      ext_s      = {p1_r, {DATA_W{1'b0}}};
      saw_s      = DATA_W'(ext_s >> PHASE_W);
      tri_base_s = DATA_W'(ext_s >> (PHASE_W - 1));
      case (m1_r)
         MODE_SINE:   wave_s = sine_s;
         MODE_SAW:    wave_s = saw_s;
         MODE_SQUARE: wave_s = p1_r[PHASE_W-1] ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
         MODE_TRI:    wave_s = p1_r[PHASE_W-1] ? ~tri_base_s : tri_base_s;
         default:     wave_s = saw_s;
      endcase
   end

   // Output register: holds under backpressure, flushed by a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld_r  <= 1'b0;
         out_data_r <= {DATA_W{1'b0}};
         out_wrap_r <= 1'b0;
      end else if (acc_clr) begin
         out_vld_r  <= 1'b0;
         out_wrap_r <= 1'b0;
      end else if (!stall_s) begin
         out_vld_r <= v1_r;
         if (v1_r) begin
            out_data_r <= wave_s;
            out_wrap_r <= w1_r;
         end else begin
            out_wrap_r <= 1'b0;
         end
      end
   end

   assign stream.out_vld  = out_vld_r;
   assign stream.out_data = out_data_r;
   assign stream.out_wrap = out_wrap_r;

endmodule

// File: tb/tb_dds_nco.sv
// tb_dds_nco: directed and randomised checks of dds_nco (16/8/8, no dither).
// Expected samples come from a closed-form model: sample k has phase
// base + k*freq + offset, waveform values from the formulas with $sin.
`timescale 1ns/1ps
module tb_dds_nco;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        en       = 1'b0;
   logic        acc_clr  = 1'b0;
   logic        cfg_load = 1'b0;
   logic [15:0] cfg_freq  = 16'h0000;
   logic [15:0] cfg_phase = 16'h0000;
   logic [1:0]  cfg_mode  = 2'd0;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model state
   int     k;
   int     m_k0;
   longint m_base;
   longint m_tprev;
   int     m_freq;
   int     m_off;
   int     m_mode;
   logic   prev_stall;

   dds_nco_if #(.DATA_W(8)) sif ();

   dds_nco #(
      .PHASE_W (16),
      .LUT_AW  (8),
      .DATA_W  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .acc_clr   (acc_clr),
      .cfg_load  (cfg_load),
      .cfg_freq  (cfg_freq),
      .cfg_phase (cfg_phase),
      .cfg_mode  (cfg_mode),
      .stream    (sif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lut_ref(input int j);
      real v;
      v = 127.0 * $sin(3.141592653589793 * real'(j) / 128.0);
      return int'($floor(v + 0.5));
   endfunction

   function automatic int wave_ref(input int ph, input int mode);
      int p, q, i, b, r;
      p = ph >> 8;
      q = p >> 6;
      i = p & 63;
      b = (ph >> 7) & 255;
      if (mode == 0) begin
         if (q == 0)      r = 128 + lut_ref(i);
         else if (q == 1) r = 128 + lut_ref(64 - i);
         else if (q == 2) r = 128 - lut_ref(i);
         else             r = 128 - lut_ref(64 - i);
      end else if (mode == 1) begin
         r = p;
      end else if (mode == 2) begin
         r = (ph >= 32768) ? 255 : 0;
      end else begin
         r = (ph >= 32768) ? 255 - b : b;
      end
      return r;
   endfunction

   // total (unwrapped) accumulated phase before sample kk
   function automatic longint accum(input int kk);
      return m_base + longint'(kk - m_k0) * longint'(m_freq);
   endfunction

   function automatic int phase_ref(input int kk);
      return int'((accum(kk) + longint'(m_off)) % 64'sd65536);
   endfunction

   function automatic logic wrap_ref(input int kk);
      longint prev;
      if (kk == m_k0) begin
         if (m_tprev < 0) return 1'b1;
         prev = m_tprev;
      end else begin
         prev = accum(kk - 1);
      end
      return (accum(kk) >>> 16) != (prev >>> 16);
   endfunction

   task automatic model_clear(input int f, input int o, input int m);
      k = 0; m_k0 = 0; m_base = 0; m_tprev = -1;
      m_freq = f; m_off = o; m_mode = m;
      prev_stall = 1'b0;
   endtask

   // configuration change with an empty pipeline: continues from current accumulator
   task automatic model_reload(input int f, input int o, input int m);
      longint t_now;
      t_now = accum(k);
      if (k != m_k0) m_tprev = accum(k - 1);
      m_base = t_now; m_k0 = k;
      m_freq = f; m_off = o; m_mode = m;
   endtask

   // Checks the presented sample against the model, then advances one clock
   task automatic tick();
      if (prev_stall) check("hold_vld", {31'd0, sif.out_vld}, 32'd1);
      if (sif.out_vld === 1'b1) begin
         check("stream_data", {24'd0, sif.out_data}, wave_ref(phase_ref(k), m_mode));
         check("stream_wrap", {31'd0, sif.out_wrap}, {31'd0, wrap_ref(k)});
         if (sif.out_rdy) k++;
      end
      prev_stall = sif.out_vld & ~sif.out_rdy & ~acc_clr;
      @(posedge clk);
      #1;
   endtask

   task automatic start_seg(input logic [15:0] f, input logic [15:0] o, input logic [1:0] m,
                            input logic en_v);
      cfg_freq = f; cfg_phase = o; cfg_mode = m;
      cfg_load = 1'b1; acc_clr = 1'b1; en = en_v;
      tick();
      cfg_load = 1'b0; acc_clr = 1'b0;
      model_clear(int'(f), int'(o), int'(m));
   endtask

   task automatic run_pattern(input string tag, input logic [1:0] mode, input logic [31:0] pat);
      sif.out_rdy = 1'b1;
      start_seg(16'h4000, 16'h0000, mode, 1'b0);
      en = 1'b1;
      tick();
      check({tag, "_lat1"}, {31'd0, sif.out_vld}, 32'd0);
      tick();
      check({tag, "_lat2"}, {31'd0, sif.out_vld}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         check({tag, "_data"}, {24'd0, sif.out_data}, {24'd0, pat[31 - 8 * (i % 4) -: 8]});
         check({tag, "_wrap"}, {31'd0, sif.out_wrap}, (i % 4 == 0) ? 32'd1 : 32'd0);
         tick();
      end
   endtask

   initial begin
      int f, o, m;
      sif.out_rdy = 1'b1;
      model_clear(0, 0, 0);

      // reset state
      #2;
      check("rst_vld",  {31'd0, sif.out_vld},  32'd0);
      check("rst_data", {24'd0, sif.out_data}, 32'd0);
      check("rst_wrap", {31'd0, sif.out_wrap}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // saw ramp, latency, wrap at 256 samples
      start_seg(16'h0100, 16'h0000, 2'd1, 1'b0);
      en = 1'b1;
      tick();
      check("saw_lat1", {31'd0, sif.out_vld}, 32'd0);
      tick();
      check("saw_lat2",   {31'd0, sif.out_vld},  32'd1);
      check("saw_first",  {24'd0, sif.out_data}, 32'h00);
      check("saw_wrap0",  {31'd0, sif.out_wrap}, 32'd1);
      tick();
      check("saw_second", {24'd0, sif.out_data}, 32'h01);
      for (int i = 0; i < 254; i++) tick();
      check("saw_last",   {24'd0, sif.out_data}, 32'hFF);
      check("saw_nowrap", {31'd0, sif.out_wrap}, 32'd0);
      tick();
      check("saw_roll",   {24'd0, sif.out_data}, 32'h00);
      check("saw_wrap1",  {31'd0, sif.out_wrap}, 32'd1);

      // backpressure mid-stream
      for (int i = 0; i < 5; i++) begin
         sif.out_rdy = 1'b0;
         tick();
         check("bp_vld", {31'd0, sif.out_vld}, 32'd1);
      end
      sif.out_rdy = 1'b1;
      for (int i = 0; i < 10; i++) tick();

      // clear with en high plus new config: two bubbles then FF with wrap
      start_seg(16'h0100, 16'h8000, 2'd2, 1'b1);
      check("clr_bubble1", {31'd0, sif.out_vld}, 32'd0);
      tick();
      check("clr_bubble2", {31'd0, sif.out_vld}, 32'd0);
      tick();
      check("clr_vld",  {31'd0, sif.out_vld},  32'd1);
      check("clr_data", {24'd0, sif.out_data}, 32'hFF);
      check("clr_wrap", {31'd0, sif.out_wrap}, 32'd1);
      for (int i = 0; i < 4; i++) tick();

      // fixed quarter-cycle patterns
      run_pattern("square", 2'd2, 32'h0000FFFF);
      run_pattern("sine",   2'd0, 32'h80FF8001);
      run_pattern("tri",    2'd3, 32'h0080FF7F);

      // randomised segments: random en/ready, mid-segment reload after a drain
      for (int s = 0; s < 5; s++) begin
         f = (s == 4) ? 0 : int'($urandom_range(1, 65535));
         o = int'($urandom_range(0, 65535));
         m = int'($urandom_range(0, 3));
         start_seg(16'(f), 16'(o), 2'(m), 1'b0);
         for (int c = 0; c < 150; c++) begin
            en          = ($urandom_range(0, 3) != 0);
            sif.out_rdy = ($urandom_range(0, 2) != 0);
            tick();
         end
         en = 1'b0;
         sif.out_rdy = 1'b1;
         for (int c = 0; c < 3; c++) tick();
         check("drain_vld", {31'd0, sif.out_vld}, 32'd0);
         f = int'($urandom_range(0, 65535));
         o = int'($urandom_range(0, 65535));
         m = int'($urandom_range(0, 3));
         cfg_freq = 16'(f); cfg_phase = 16'(o); cfg_mode = 2'(m);
         cfg_load = 1'b1;
         tick();
         cfg_load = 1'b0;
         model_reload(f, o, m);
         for (int c = 0; c < 150; c++) begin
            en          = ($urandom_range(0, 3) != 0);
            sif.out_rdy = ($urandom_range(0, 2) != 0);
            tick();
         end
      end

      // asynchronous reset mid-stream, then default config gives constant midpoint
      start_seg(16'h0100, 16'h0000, 2'd1, 1'b1);
      sif.out_rdy = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_vld",  {31'd0, sif.out_vld},  32'd0);
      check("arst_data", {24'd0, sif.out_data}, 32'd0);
      check("arst_wrap", {31'd0, sif.out_wrap}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear(0, 0, 0);
      en = 1'b1;
      tick();
      tick();
      check("post_rst_data", {24'd0, sif.out_data}, 32'h80);
      check("post_rst_wrap", {31'd0, sif.out_wrap}, 32'd1);
      tick();
      check("post_rst_data2", {24'd0, sif.out_data}, 32'h80);
      check("post_rst_wrap2", {31'd0, sif.out_wrap}, 32'd0);
      for (int i = 0; i < 10; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
